// File: rtl/bubbledrive8_ledseq.sv
// Multi-channel status-LED pattern generator: shared tick prescaler, phase-locked
// slow/fast blink and per-channel N-flash error codes, with registered LED drive.
module bubbledrive8_ledseq #(
    parameter int CH         = 4,
    parameter int TICK_DIV   = 48000,
    parameter int SLOW_T     = 500,
    parameter int FAST_T     = 125,
    parameter int CODE_ON_T  = 200,
    parameter int CODE_OFF_T = 300,
    parameter int CODE_GAP_T = 1500,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            MCLK,
    input  logic            nRST,
    input  logic [3*CH-1:0] MODE,
    input  logic [4*CH-1:0] CODE,
    input  logic            SYNC,
    output logic [CH-1:0]   nLED,
    output logic            TICK
);

    localparam int MAX_A = (SLOW_T > FAST_T) ? SLOW_T : FAST_T;
    localparam int MAX_B = (CODE_ON_T > CODE_OFF_T) ? CODE_ON_T : CODE_OFF_T;
    localparam int MAX_C = (CODE_GAP_T > TICK_DIV) ? CODE_GAP_T : TICK_DIV;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int CW    = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        ST_ON  = 2'b00,
        ST_OFF = 2'b01,
        ST_GAP = 2'b10
    } code_st_e;

    logic [CW-1:0] pre_r;
    logic          tick_r;
    logic [CW-1:0] slow_cnt_r;
    logic [CW-1:0] fast_cnt_r;
    logic          slow_ph_r;
    logic          fast_ph_r;
    logic [CH-1:0] lit_s;
    logic [CH-1:0] nled_r;

    // Tick prescaler; TICK fires the cycle after the count reaches its terminal value
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            pre_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (SYNC) begin
            pre_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (pre_r == CW'(TICK_DIV - 1)) begin
            pre_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            pre_r  <= pre_r + CW'(1'b1);
            tick_r <= 1'b0;
        end
    end

    // Shared slow/fast blink phases, so every blinking channel stays aligned
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            slow_cnt_r <= {CW{1'b0}};
            fast_cnt_r <= {CW{1'b0}};
            slow_ph_r  <= 1'b1;
            fast_ph_r  <= 1'b1;
        end else if (SYNC) begin
            slow_cnt_r <= {CW{1'b0}};
            fast_cnt_r <= {CW{1'b0}};
            slow_ph_r  <= 1'b1;
            fast_ph_r  <= 1'b1;
        end else if (tick_r) begin
            if (slow_cnt_r == CW'(SLOW_T - 1)) begin
                slow_cnt_r <= {CW{1'b0}};
                slow_ph_r  <= ~slow_ph_r;
            end else begin
                slow_cnt_r <= slow_cnt_r + CW'(1'b1);
            end
            if (fast_cnt_r == CW'(FAST_T - 1)) begin
                fast_cnt_r <= {CW{1'b0}};
                fast_ph_r  <= ~fast_ph_r;
            end else begin
                fast_cnt_r <= fast_cnt_r + CW'(1'b1);
            end
        end else begin
            slow_cnt_r <= slow_cnt_r;
            fast_cnt_r <= fast_cnt_r;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [2:0]    mode_s;
        logic [3:0]    code_s;
        logic          force_s;
        logic          ch_lit_s;
        code_st_e      st_r;
        logic [CW-1:0] t_r;
        logic [3:0]    n_r;
        logic [3:0]    lat_r;
        logic [2:0]    prev_mode_r;

        assign mode_s  = MODE[3*i +: 3];
        assign code_s  = CODE[4*i +: 4];
        // Held in the entry state outside code mode, on the entry cycle itself, and during SYNC
        assign force_s = SYNC || (mode_s != 3'b100) || (prev_mode_r != 3'b100);

        // Per-channel flash-code sequencer; a zero code parks the channel in the dark gap
        always_ff @(posedge MCLK or negedge nRST) begin
            if (!nRST) begin
                st_r        <= ST_ON;
                t_r         <= {CW{1'b0}};
                n_r         <= 4'd0;
                lat_r       <= 4'd0;
                prev_mode_r <= 3'b000;
            end else begin
                prev_mode_r <= mode_s;
                if (force_s) begin
                    st_r  <= (code_s == 4'd0) ? ST_GAP : ST_ON;
                    t_r   <= {CW{1'b0}};
                    n_r   <= 4'd0;
                    lat_r <= code_s;
                end else if (tick_r) begin
                    case (st_r)
                        ST_ON: begin
                            if (t_r == CW'(CODE_ON_T - 1)) begin
                                t_r <= {CW{1'b0}};
                                n_r <= n_r + 4'd1;
                                if (({1'b0, n_r} + 5'd1) >= {1'b0, lat_r}) begin
                                    st_r <= ST_GAP;
                                end else begin
                                    st_r <= ST_OFF;
                                end
                            end else begin
                                t_r <= t_r + CW'(1'b1);
                            end
                        end
                        ST_OFF: begin
                            if (t_r == CW'(CODE_OFF_T - 1)) begin
                                t_r  <= {CW{1'b0}};
                                st_r <= ST_ON;
                            end else begin
                                t_r <= t_r + CW'(1'b1);
                            end
                        end
                        ST_GAP: begin
                            if (t_r == CW'(CODE_GAP_T - 1)) begin
                                t_r   <= {CW{1'b0}};
                                n_r   <= 4'd0;
                                lat_r <= code_s;
                                st_r  <= (code_s == 4'd0) ? ST_GAP : ST_ON;
                            end else begin
                                t_r <= t_r + CW'(1'b1);
                            end
                        end
                        default: begin
                            st_r <= ST_GAP;
                            t_r  <= {CW{1'b0}};
                            n_r  <= 4'd0;
                        end
                    endcase
                end else begin
                    st_r <= st_r;
                end
            end
        end

        // Lit decode from the channel mode and the shared/per-channel state
        always_comb begin
            ch_lit_s = 1'b0;
            case (mode_s)
                3'b001:  ch_lit_s = 1'b1;
                3'b010:  ch_lit_s = slow_ph_r;
                3'b011:  ch_lit_s = fast_ph_r;
                3'b100:  ch_lit_s = (st_r == ST_ON);
                3'b101:  ch_lit_s = ~slow_ph_r;
                default: ch_lit_s = 1'b0;
            endcase
        end

        assign lit_s[i] = ch_lit_s;
    end

    // Registered LED drive with configurable polarity
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            nled_r <= {CH{ACTIVE_LOW}};
        end else if (ACTIVE_LOW) begin
            nled_r <= ~lit_s;
        end else begin
            nled_r <= lit_s;
        end
    end

    assign nLED = nled_r;
    assign TICK = tick_r;

endmodule

// File: tb/tb_bubbledrive8_ledseq.sv
// Bench for bubbledrive8_ledseq: run-length vector table, directed corner sequences
// and randomized stimulus against a tick/position-based reference model.
module tb_bubbledrive8_ledseq;

    localparam int CH   = 4;
    localparam int TD   = 4;
    localparam int SLOW = 5;
    localparam int FAST = 2;
    localparam int TON  = 2;
    localparam int TOFF = 2;
    localparam int TGAP = 6;
    localparam int CAP  = 60;

    logic        MCLK = 1'b0;
    logic        nRST;
    logic [11:0] MODE;
    logic [15:0] CODE;
    logic        SYNC;
    logic [3:0]  nLED;
    logic        TICK;

    int n_checks = 0;
    int n_fail   = 0;

    bubbledrive8_ledseq #(
        .CH(CH), .TICK_DIV(TD), .SLOW_T(SLOW), .FAST_T(FAST),
        .CODE_ON_T(TON), .CODE_OFF_T(TOFF), .CODE_GAP_T(TGAP), .ACTIVE_LOW(1'b1)
    ) dut (
        .MCLK(MCLK), .nRST(nRST), .MODE(MODE), .CODE(CODE),
        .SYNC(SYNC), .nLED(nLED), .TICK(TICK)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since restart, ticks consumed, per-channel position in code cycle
    int       m_e, m_k;
    int       m_p[CH], m_lat[CH], m_prev[CH];
    logic [3:0] m_exp_nled;
    bit       m_exp_tick;
    bit       m_valid = 1'b0;

    function automatic bit code_lit(input int p, input int lat);
        int active = lat * (TON + TOFF) - TOFF;
        return (lat > 0) && (p < active) && ((p % (TON + TOFF)) < TON);
    endfunction

    function automatic int code_len(input int lat);
        return (lat == 0) ? TGAP : lat * (TON + TOFF) - TOFF + TGAP;
    endfunction

    task automatic model_step();
        bit tick_now = (m_e > 0) && (m_e % TD == 0);
        bit slow_lit = ((m_k / SLOW) % 2) == 0;
        bit fast_lit = ((m_k / FAST) % 2) == 0;
        logic [3:0] lit;
        for (int c = 0; c < CH; c++) begin
            int md = int'(MODE[3*c +: 3]);
            int cd = int'(CODE[4*c +: 4]);
            case (md)
                1:       lit[c] = 1'b1;
                2:       lit[c] = slow_lit;
                3:       lit[c] = fast_lit;
                4:       lit[c] = code_lit(m_p[c], m_lat[c]);
                5:       lit[c] = !slow_lit;
                default: lit[c] = 1'b0;
            endcase
            if (SYNC || md != 4 || m_prev[c] != 4) begin
                m_p[c]   = 0;
                m_lat[c] = cd;
            end else if (tick_now) begin
                m_p[c]++;
                if (m_p[c] >= code_len(m_lat[c])) begin
                    m_p[c]   = 0;
                    m_lat[c] = cd;
                end
            end
            m_prev[c] = md;
        end
        m_exp_nled = ~lit;
        m_k = SYNC ? 0 : m_k + (tick_now ? 1 : 0);
        m_e = SYNC ? 0 : m_e + 1;
        m_exp_tick = (m_e > 0) && (m_e % TD == 0);
    endtask

    always @(negedge MCLK) begin
        if (!nRST) begin
            check("reset_nled", int'(nLED), 15);
            check("reset_tick", int'(TICK), 0);
            m_e = 0;
            m_k = 0;
            for (int c = 0; c < CH; c++) begin
                m_p[c] = 0; m_lat[c] = 0; m_prev[c] = 0;
            end
            m_exp_nled = 4'hF;
            m_exp_tick = 1'b0;
            m_valid    = 1'b1;
        end else begin
            if (m_valid) begin
                check("model_nled", int'(nLED), int'(m_exp_nled));
                check("model_tick", int'(TICK), int'(m_exp_tick));
            end
            model_step();
        end
    end

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic do_sync(input logic [2:0] m, input logic [3:0] c);
        MODE = {4{m}};
        CODE = {4{c}};
        SYNC = 1'b1;
        cyc();
        cyc();
        SYNC = 1'b0;
    endtask

    int runs_a[8];
    int first_lvl;

    // Measures consecutive lit/dark run lengths on one channel, optionally changing CODE mid-way
    task automatic measure(input int ch, input int nruns, input int chg_at, input int chg_code);
        int s, cur, idx;
        bit lvl, l;
        cyc();
        s = 1;
        lvl = (nLED[ch] == 1'b0);
        first_lvl = int'(lvl);
        cur = 1;
        idx = 0;
        while (idx < nruns) begin
            cyc();
            s++;
            if (s == chg_at) CODE = {4{chg_code[3:0]}};
            l = (nLED[ch] == 1'b0);
            if (l == lvl && cur < CAP) begin
                cur++;
            end else begin
                runs_a[idx] = cur;
                idx++;
                cur = 1;
                lvl = l;
            end
        end
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [3:0] code;
        int         ch;
        int         first;
        int         runs[6];
    } vec_t;

    vec_t vecs[9];

    task automatic set_vec(input int i, input logic [2:0] m, input logic [3:0] c, input int ch,
                           input int f, input int r0, input int r1, input int r2,
                           input int r3, input int r4, input int r5);
        vecs[i].mode = m;  vecs[i].code = c;  vecs[i].ch = ch;  vecs[i].first = f;
        vecs[i].runs[0] = r0; vecs[i].runs[1] = r1; vecs[i].runs[2] = r2;
        vecs[i].runs[3] = r3; vecs[i].runs[4] = r4; vecs[i].runs[5] = r5;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_b[8];
        int exp_c[5];
        int w;

        set_vec(0, 3'b010, 4'd0, 0, 1, 21, 20, 20, 20, 20, 20);
        set_vec(1, 3'b101, 4'd0, 1, 0, 21, 20, 20, 20, 20, 20);
        set_vec(2, 3'b011, 4'd0, 2, 1,  9,  8,  8,  8,  8,  8);
        set_vec(3, 3'b100, 4'd3, 3, 1,  9,  8,  8,  8,  8, 24);
        set_vec(4, 3'b100, 4'd1, 0, 1,  9, 24,  8, 24,  8, 24);
        set_vec(5, 3'b001, 4'd0, 1, 1, CAP, CAP, CAP, CAP, CAP, CAP);
        set_vec(6, 3'b000, 4'd5, 2, 0, CAP, CAP, CAP, CAP, CAP, CAP);
        set_vec(7, 3'b111, 4'd2, 3, 0, CAP, CAP, CAP, CAP, CAP, CAP);
        set_vec(8, 3'b100, 4'd0, 1, 0, CAP, CAP, CAP, CAP, CAP, CAP);

        // Reset release: LEDs dark, TICK every 4th cycle
        nRST = 1'b0; MODE = 12'h000; CODE = 16'h0000; SYNC = 1'b0;
        cyc(); cyc();
        nRST = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check($sformatf("tick_after_reset_%0d", i), int'(TICK), (i % 4 == 0) ? 1 : 0);
            check($sformatf("nled_after_reset_%0d", i), int'(nLED), 15);
        end

        for (int i = 0; i < 9; i++) begin
            do_sync(vecs[i].mode, vecs[i].code);
            measure(vecs[i].ch, 6, -1, 0);
            check($sformatf("vec%0d_first_lit", i), first_lvl, vecs[i].first);
            for (int j = 0; j < 6; j++)
                check($sformatf("vec%0d_run%0d", i, j), runs_a[j], vecs[i].runs[j]);
        end

        // CODE 3 -> 1 during the second flash
        exp_b = '{9, 8, 8, 8, 8, 24, 8, 24};
        do_sync(3'b100, 4'd3);
        measure(0, 8, 20, 1);
        for (int j = 0; j < 8; j++)
            check($sformatf("code_3to1_run%0d", j), runs_a[j], exp_b[j]);

        // CODE 0 parks the channel dark; 2 takes effect at the next gap end
        exp_c = '{49, 8, 8, 8, 24};
        do_sync(3'b100, 4'd0);
        measure(0, 5, 30, 2);
        check("code_0to2_first_lit", first_lvl, 0);
        for (int j = 0; j < 5; j++)
            check($sformatf("code_0to2_run%0d", j), runs_a[j], exp_c[j]);

        // SYNC pulse during the dark slow phase restarts lit
        do_sync(3'b010, 4'd0);
        w = 0;
        while (nLED[0] == 1'b0 && w < CAP) begin
            cyc();
            w++;
        end
        check("sync_wait_dark", (w < CAP) ? 1 : 0, 1);
        cyc(); cyc(); cyc();
        SYNC = 1'b1;
        cyc();
        SYNC = 1'b0;
        check("sync_edge_still_dark", int'(nLED), 15);
        check("sync_edge_tick", int'(TICK), 0);
        cyc();
        check("sync_restart_lit", int'(nLED), 0);

        // nRST mid-code: LEDs dark immediately
        do_sync(3'b100, 4'd3);
        cyc(); cyc(); cyc(); cyc(); cyc();
        nRST = 1'b0;
        #1;
        check("async_reset_nled", int'(nLED), 15);
        check("async_reset_tick", int'(TICK), 0);
        cyc();
        MODE = 12'h000; CODE = 16'h0000;
        cyc();
        nRST = 1'b1;

        // Randomized stimulus, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (i == 1500) begin
                nRST = 1'b0;
                cyc();
                MODE = 12'h000; SYNC = 1'b0;
                cyc();
                nRST = 1'b1;
            end else begin
                int c = int'($urandom_range(0, CH - 1));
                if ($urandom_range(0, 29) == 0) MODE[3*c +: 3] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 49) == 0) CODE[4*c +: 4] = 4'($urandom_range(0, 4));
                SYNC = ($urandom_range(0, 199) == 0);
            end
        end
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
